// File: rtl/uart_pkg.sv
// Package: uart_pkg
// Items shared between the UART receiver and transmitter: the receiver state
// encoding and the frame-shape constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   // Payload bits per frame.
   localparam int DATA_BITS = 8;

   // Bits per frame with one stop bit: start + 8 data + stop.
   localparam int bit_count_done = 10;

endpackage

// File: rtl/uart_sync2.sv
// Module: uart_sync2
// Two-flop synchronizer for a single asynchronous bit.
// Both flops reset to 1, which is the idle level of a serial line.
// Ports:
//   clock       in   system clock
//   tick_reset  in   synchronous, active-high reset
//   tick_async  in   asynchronous input bit
//   line        out  synchronized copy of tick_async, 2 clocks late
module uart_sync2 (
   input  logic clock,
   input  logic tick_reset,
   input  logic tick_async,
   output logic line
);

   logic sync_p0;
   logic sync_p1;

   always_ff @(posedge clock) begin
      if (tick_reset) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         // stage 0: first capture, may go metastable
         sync_p0 <= tick_async;
         // stage 1: settled value
         sync_p1 <= sync_p0;
      end
   end

   assign line = sync_p1;

endmodule

// File: rtl/uart_rx.sv
// Module: uart_rx
// Serial receiver: 1 start bit, 8 data bits LSB first, 1 or more stop bits.
// Each bit is sampled once, at mid-bit, from the synchronized line.
// A good frame produces a 1-cycle get_valid_ret pulse with the byte held in
// get_buffer_ret; a low stop bit produces a 1-cycle get_error_ret pulse.
// Optional feature macro: UART_RX_CHECKSUM_EN adds a 32-bit running sum of
// all good bytes on get_checksum_ret.
// Ports:
//   clock             in   system clock
//   tick_reset        in   synchronous, active-high reset
//   tick_serial       in   raw serial line, idles high, asynchronous
//   get_valid_ret     out  1-cycle pulse: new byte in get_buffer_ret
//   get_buffer_ret    out  last good byte, held until the next good byte
//   get_error_ret     out  1-cycle pulse: framing error
//   get_busy_ret      out  receiver is not idle
//   get_checksum_ret  out  sum of good bytes mod 2^32 (UART_RX_CHECKSUM_EN only)
module uart_rx
   import uart_pkg::*;
#(
   parameter int cycles_per_bit = 4
) (
   input  logic        clock,
   input  logic        tick_reset,
   input  logic        tick_serial,
   output logic        get_valid_ret,
   output logic [7:0]  get_buffer_ret,
   output logic        get_error_ret,
   output logic        get_busy_ret
`ifdef UART_RX_CHECKSUM_EN
   ,
   output logic [31:0] get_checksum_ret
`endif
);

   localparam int              DW       = $clog2(cycles_per_bit);
   localparam logic [DW-1:0]   HALF     = DW'((cycles_per_bit - 1) / 2);
   localparam logic [DW-1:0]   LAST     = DW'(cycles_per_bit - 1);
   localparam logic [3:0]      LAST_BIT = 4'(DATA_BITS - 1);

   logic                 line;
   rx_state_t            state, state_n;
   logic [DW-1:0]        delay, delay_n;
   logic [3:0]           count, count_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic [7:0]           buffer_n;
   logic                 valid_n;
   logic                 error_n;

   uart_sync2 u_sync (
      .clock      (clock),
      .tick_reset (tick_reset),
      .tick_async (tick_serial),
      .line       (line)
   );

   always_ff @(posedge clock) begin
      if (tick_reset) begin
         state          <= IDLE;
         delay          <= '0;
         count          <= '0;
         shift          <= '0;
         get_buffer_ret <= '0;
         get_valid_ret  <= 1'b0;
         get_error_ret  <= 1'b0;
      end else begin
         state          <= state_n;
         delay          <= delay_n;
         count          <= count_n;
         shift          <= shift_n;
         get_buffer_ret <= buffer_n;
         get_valid_ret  <= valid_n;
         get_error_ret  <= error_n;
      end
   end

   always_comb begin
      state_n  = state;
      delay_n  = delay;
      count_n  = count;
      shift_n  = shift;
      buffer_n = get_buffer_ret;
      valid_n  = 1'b0;
      error_n  = 1'b0;
      case (state)
         IDLE: begin
            if (!line) begin
               state_n = START;
               delay_n = '0;
            end
         end
         START: begin
            // Re-check the line at mid start bit so a short glitch is dropped.
            if (delay < HALF) begin
               delay_n = delay + 1'b1;
            end else if (!line) begin
               state_n = DATA;
               delay_n = '0;
               count_n = '0;
            end else begin
               state_n = IDLE;
            end
         end
         DATA: begin
            if (delay < LAST) begin
               delay_n = delay + 1'b1;
            end else begin
               shift_n = {line, shift[DATA_BITS-1:1]};
               delay_n = '0;
               count_n = count + 4'd1;
               if (count == LAST_BIT) state_n = STOP;
            end
         end
         STOP: begin
            // Leaving at mid stop bit leaves half a bit to catch the next start edge.
            if (delay < LAST) begin
               delay_n = delay + 1'b1;
            end else if (line) begin
               valid_n  = 1'b1;
               buffer_n = shift;
               delay_n  = '0;
               state_n  = IDLE;
            end else begin
               error_n = 1'b1;
               delay_n = '0;
               state_n = WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            // A held-low line (break) must not look like a fresh start bit.
            if (line) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign get_busy_ret = (state != IDLE);

`ifdef UART_RX_CHECKSUM_EN
   always_ff @(posedge clock) begin
      if (tick_reset) begin
         get_checksum_ret <= '0;
      end else if (valid_n) begin
         get_checksum_ret <= get_checksum_ret + {24'h0, shift};
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench: tb_uart_rx
// Drives serial frames onto tick_serial bit by bit and checks received bytes
// and framing errors against an expected-event queue filled by the frame
// generator (a good frame yields its byte, a low stop bit yields an error).
module tb_uart_rx;

   localparam int CPB = 4;

   logic        clock = 1'b0;
   logic        tick_reset = 1'b1;
   logic        tick_serial = 1'b1;
   logic        valid;
   logic [7:0]  buffer;
   logic        error;
   logic        busy;
`ifdef UART_RX_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   uart_rx #(.cycles_per_bit(CPB)) dut (
      .clock            (clock),
      .tick_reset       (tick_reset),
      .tick_serial      (tick_serial),
      .get_valid_ret    (valid),
      .get_buffer_ret   (buffer),
      .get_error_ret    (error),
      .get_busy_ret     (busy)
`ifdef UART_RX_CHECKSUM_EN
      ,
      .get_checksum_ret (checksum)
`endif
   );

   always #5 clock = ~clock;

   int          n_tests = 0;
   int          n_fail = 0;
   int          exp_q[$];          // -1 = framing error, else expected byte
   int          n_valid = 0;
   int          n_error = 0;
   logic [7:0]  model_buf = 8'h00;
   logic [31:0] model_sum = 32'h0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: every pulse consumes one expected event.
   initial begin
      logic prev_v;
      logic prev_e;
      int   e;
      prev_v = 1'b0;
      prev_e = 1'b0;
      forever begin
         @(negedge clock);
         if (tick_reset) begin
            prev_v = 1'b0;
            prev_e = 1'b0;
         end else begin
            if (valid || error) chk("valid_error_exclusive", 32'(valid & error), 32'h0);
            if (valid) begin
               chk("valid_width", 32'(prev_v), 32'h0);
               n_valid++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_valid", 32'(exp_q.size()), 32'h1);
               end else begin
                  e = exp_q.pop_front();
                  chk("rx_byte", 32'(buffer), 32'(e));
                  if (e >= 0) begin
                     model_buf = e[7:0];
                     model_sum = model_sum + 32'(e);
                  end
               end
            end
            if (error) begin
               chk("error_width", 32'(prev_e), 32'h0);
               n_error++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_error", 32'(exp_q.size()), 32'h1);
               end else begin
                  e = exp_q.pop_front();
                  chk("rx_error_expected", 32'(e), 32'hFFFF_FFFF);
               end
               chk("error_buffer_held", 32'(buffer), 32'(model_buf));
            end
            prev_v = valid;
            prev_e = error;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic v, input int n);
      tick_serial = v;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int nstop);
      if (stop_ok) exp_q.push_back(int'(b));
      else exp_q.push_back(-1);
      drive(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive(b[i], CPB);
      drive(stop_ok, CPB * nstop);
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         @(posedge clock);
         #1;
         k++;
      end
      chk(tag, 32'(exp_q.size()), 32'h0);
      exp_q.delete();
   endtask

   task automatic do_reset();
      tick_reset = 1'b1;
      tick_serial = 1'b1;
      drive(1'b1, 2);
      tick_reset = 1'b0;
      model_buf = 8'h00;
      model_sum = 32'h0;
      exp_q.delete();
   endtask

   initial begin
      int   v0;
      int   e0;
      logic busy_seen;
      logic [7:0] b;
      bit   ok;

      // Reset state
      do_reset();
      chk("reset_valid", 32'(valid), 32'h0);
      chk("reset_error", 32'(error), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_buffer", 32'(buffer), 32'h0);
      drive(1'b1, CPB);

      // Single frame 0x55
      v0 = n_valid;
      e0 = n_error;
      send_frame(8'h55, 1'b1, 1);
      drive(1'b1, 2 * CPB);
      drain("t55_drain");
      chk("t55_valid_count", 32'(n_valid - v0), 32'h1);
      chk("t55_buffer", 32'(buffer), 32'h55);
      chk("t55_error_count", 32'(n_error - e0), 32'h0);
      chk("t55_busy_after", 32'(busy), 32'h0);

      // Back-to-back 0x00, 0xFF with one stop bit
      v0 = n_valid;
      send_frame(8'h00, 1'b1, 1);
      send_frame(8'hFF, 1'b1, 1);
      drive(1'b1, 2 * CPB);
      drain("b2b_drain");
      chk("b2b_valid_count", 32'(n_valid - v0), 32'h2);
      chk("b2b_buffer", 32'(buffer), 32'hFF);

      // One-clock glitch
      v0 = n_valid;
      e0 = n_error;
      busy_seen = 1'b0;
      tick_serial = 1'b0;
      @(posedge clock);
      #1;
      tick_serial = 1'b1;
      for (int i = 0; i < 4 * CPB; i++) begin
         @(negedge clock);
         if (busy) busy_seen = 1'b1;
      end
      @(posedge clock);
      #1;
      chk("glitch_busy_seen", 32'(busy_seen), 32'h1);
      chk("glitch_busy_after", 32'(busy), 32'h0);
      chk("glitch_no_valid", 32'(n_valid - v0), 32'h0);
      chk("glitch_no_error", 32'(n_error - e0), 32'h0);
      chk("glitch_buffer", 32'(buffer), 32'hFF);

      // Framing error on 0xA5 with line held low, then good 0x3C
      v0 = n_valid;
      e0 = n_error;
      send_frame(8'hA5, 1'b0, 1);
      drive(1'b0, 8);
      chk("ferr_error_count", 32'(n_error - e0), 32'h1);
      chk("ferr_busy_low_line", 32'(busy), 32'h1);
      chk("ferr_buffer_held", 32'(buffer), 32'hFF);
      drive(1'b0, 8);
      chk("ferr_busy_still", 32'(busy), 32'h1);
      drive(1'b1, 3 * CPB);
      chk("ferr_busy_released", 32'(busy), 32'h0);
      send_frame(8'h3C, 1'b1, 1);
      drive(1'b1, 2 * CPB);
      drain("ferr_drain");
      chk("ferr_next_buffer", 32'(buffer), 32'h3C);
      chk("ferr_valid_count", 32'(n_valid - v0), 32'h1);
      chk("ferr_error_total", 32'(n_error - e0), 32'h1);

      // Reset during data bit 4 of 0x81, then 0x7E
      b = 8'h81;
      drive(1'b0, CPB);
      for (int i = 0; i < 4; i++) drive(b[i], CPB);
      drive(b[4], 2);
      tick_reset = 1'b1;
      tick_serial = 1'b1;
      @(posedge clock);
      #1;
      chk("midrst_valid", 32'(valid), 32'h0);
      chk("midrst_error", 32'(error), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_buffer", 32'(buffer), 32'h0);
`ifdef UART_RX_CHECKSUM_EN
      chk("midrst_checksum", checksum, 32'h0);
`endif
      tick_reset = 1'b0;
      model_buf = 8'h00;
      model_sum = 32'h0;
      v0 = n_valid;
      e0 = n_error;
      drive(1'b1, 12 * CPB);
      chk("midrst_no_valid", 32'(n_valid - v0), 32'h0);
      chk("midrst_no_error", 32'(n_error - e0), 32'h0);
      send_frame(8'h7E, 1'b1, 1);
      drive(1'b1, 2 * CPB);
      drain("midrst_drain");
      chk("midrst_next_buffer", 32'(buffer), 32'h7E);

      // Randomized frames: random bytes, stop lengths, gaps and framing errors
      for (int n = 0; n < 40; n++) begin
         b = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 5) != 0);
         if (ok) begin
            send_frame(b, 1'b1, int'($urandom_range(1, 2)));
         end else begin
            send_frame(b, 1'b0, 1);
            drive(1'b1, 2 * CPB);
         end
         drive(1'b1, int'($urandom_range(0, 6)));
      end
      drive(1'b1, 2 * CPB);
      drain("rand_drain");
      chk("rand_buffer", 32'(buffer), 32'(model_buf));
      chk("rand_busy_after", 32'(busy), 32'h0);

`ifdef UART_RX_CHECKSUM_EN
      do_reset();
      drive(1'b1, CPB);
      send_frame(8'h10, 1'b1, 1);
      send_frame(8'h20, 1'b1, 1);
      send_frame(8'hFF, 1'b1, 1);
      drive(1'b1, 2 * CPB);
      drain("csum_drain");
      chk("csum_value", checksum, 32'h0000_012F);
      chk("csum_model", checksum, model_sum);
      do_reset();
      chk("csum_after_reset", checksum, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
